risc_v_load_store_unit: RTL and testbench
=========================================

RISC_V_LOAD_STORE_UNIT -- requirements
Module: risc_v_load_store_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, width of core and memory address ports.
REQ-002 SHALL have port: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req_valid in 1, req_ready out 1, req_store in 1, req_funct3 in 3, req_addr in ADDR_W, req_wdata in 32 (core request).
REQ-005 SHALL have ports: resp_valid out 1, resp_ready in 1, resp_rdata out 32, resp_err out 1 (core response).
REQ-006 SHALL have ports: mem_addr out ADDR_W, mem_din out 32, mem_we out 1, mem_dout in 32 (word memory; combinational read, write on rising clk when mem_we=1, word index = addr>>2).

Function
REQ-007 SHALL accept a request in the cycle req_valid=1 and req_ready=1; req_ready SHALL be 1 only in IDLE.
REQ-008 SHALL register store flag, funct3, addr and wdata at acceptance; request inputs SHALL be ignored outside acceptance.
REQ-009 SHALL use FSM states IDLE, RD0, RD1, WR0, WR1, RESP.
REQ-010 SHALL support loads LB 000, LH 001, LW 010, LBU 100, LHU 101 and stores SB 000, SH 001, SW 010; any other funct3 SHALL go IDLE->RESP with resp_err=1 and no memory write.
REQ-011 Aligned load: IDLE->RD0->RESP; RD0 drives mem_addr={addr[ADDR_W-1:2],2'b00} and captures mem_dout; resp_valid asserts 2 cycles after acceptance.
REQ-012 Load data SHALL be lane-selected by addr[1:0] (LH by addr[1]), sign-extended for LB/LH, zero-extended for LBU/LHU.
REQ-013 Aligned SW: IDLE->WR0->RESP, mem_we=1 for exactly one cycle with mem_din=wdata.
REQ-014 Aligned SB/SH: IDLE->RD0->WR0->RESP (read-modify-write); only the addressed lanes SHALL change, others written back unchanged.
REQ-015 Misaligned = LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
REQ-016 RESP SHALL hold resp_valid, resp_rdata, resp_err stable until resp_ready=1, then return to IDLE next cycle; back-to-back requests SHALL be accepted the cycle after.
REQ-017 resp_rdata SHALL be 0 for stores and erroring requests.
REQ-018 mem_we SHALL be 1 only in WR0/WR1; mem_addr and mem_din SHALL be 0 in IDLE and RESP.

Reset
REQ-019 rst SHALL asynchronously force state IDLE, req_ready=1 after release, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_din=0.
REQ-020 rst mid-operation SHALL abort the access with no further memory write and no response.

Configuration
REQ-021 Macro RISC_V_LSU_MISALIGN_SPLIT_EN SHALL select misaligned handling.
REQ-022 Defined: misaligned access SHALL use both words (RD0 low word, RD1 next word at aligned+4; stores then WR0, WR1), bytes merged little-endian, resp_err=0; a word on the high side that receives no bytes SHALL still be rewritten unchanged.
REQ-023 Undefined: misaligned access SHALL go IDLE->RESP with resp_err=1, no memory access, states RD1/WR1 absent.

Structure
REQ-024 Package risc_v_lsu_pkg SHALL hold funct3 constants and the FSM state type.
REQ-025 Sub-module risc_v_lsu_align SHALL implement combinational lane extract/extend and store-merge.

Verification
REQ-026 mem[0x10]=0xDEADBEEF; LB 0x11 -> resp_rdata=0xFFFFFFBE; LBU 0x11 -> 0x000000BE; resp 2 cycles after accept.
REQ-027 SH 0x12 wdata 0x00001234 -> one mem_we pulse, mem[0x10]=0x1234BEEF, resp_err=0.
REQ-028 mem[0x14]=0x00C0FFEE, LW 0x12: macro defined -> 0xFFEEDEAD; undefined -> resp_err=1, rdata 0, no mem access.
REQ-029 funct3=011 load -> resp_err=1 one cycle after accept; resp_ready held 0 for 3 cycles -> outputs stable throughout.
REQ-030 rst asserted during WR0 of SB 0x10 -> mem_we drops immediately, mem[0x10] unchanged, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/risc_v_lsu_pkg.sv
// Shared constants and FSM state type for the RISC-V load/store unit.
// Build option RISC_V_LSU_MISALIGN_SPLIT_EN enables two-word misaligned accesses (adds RD1/WR1).
package risc_v_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

`ifdef RISC_V_LSU_MISALIGN_SPLIT_EN
  localparam bit MISALIGN_SPLIT = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    WR0  = 3'd3,
    WR1  = 3'd4,
    RESP = 3'd5
  } lsu_state_e;
`else
  localparam bit MISALIGN_SPLIT = 1'b0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    WR0  = 3'd3,
    RESP = 3'd5
  } lsu_state_e;
`endif

  function automatic logic funct3_ok(input logic store, input logic [2:0] f3);
    if (store) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Only meaningful for funct3 values that passed funct3_ok.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/risc_v_lsu_align.sv
// Combinational lane extraction/extension for loads and byte-lane merge for stores,
// operating on a little-endian two-word window {word_hi, word_lo}.
module risc_v_lsu_align
  import risc_v_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_lo_i,
  input  logic [31:0] word_hi_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_lo_o,
  output logic [31:0] st_hi_o
);

  logic [63:0] window;
  logic [63:0] shifted;
  logic [63:0] size_mask;
  logic [63:0] st_mask;
  logic [63:0] st_data;
  logic [63:0] merged;
  logic [31:0] raw;
  logic [5:0]  bit_off;

  always_comb begin
    window    = {word_hi_i, word_lo_i};
    bit_off   = {1'b0, offset_i, 3'b000};
    shifted   = window >> bit_off;
    raw       = shifted[31:0];
    ld_data_o = raw;
    size_mask = 64'h0000_0000_FFFF_FFFF;
    case (funct3_i[1:0])
      2'b00: begin
        ld_data_o = funct3_i[2] ? {24'd0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
        size_mask = 64'h0000_0000_0000_00FF;
      end
      2'b01: begin
        ld_data_o = funct3_i[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
        size_mask = 64'h0000_0000_0000_FFFF;
      end
      default: begin
        ld_data_o = raw;
        size_mask = 64'h0000_0000_FFFF_FFFF;
      end
    endcase
    // Lanes outside the mask keep the previously read contents.
    st_mask = size_mask << bit_off;
    st_data = {32'd0, wdata_i} << bit_off;
    merged  = (window & ~st_mask) | (st_data & st_mask);
  end

  assign st_lo_o = merged[31:0];
  assign st_hi_o = merged[63:32];

endmodule

// File: rtl/risc_v_load_store_unit.sv
// RISC-V load/store unit: one request at a time, byte/half/word access to a word memory.
// Define RISC_V_LSU_MISALIGN_SPLIT_EN to split misaligned accesses over two words; otherwise they error.
module risc_v_load_store_unit
  import risc_v_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_din_o,
  output logic              mem_we_o,
  input  logic [31:0]       mem_dout_i
);

  lsu_state_e        state_q, state_d;
  logic              err_q, err_d;
  logic              store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rd0_q;
  logic [31:0]       rdata_q;
`ifdef RISC_V_LSU_MISALIGN_SPLIT_EN
  logic [31:0]       rd1_q;
`endif

  logic              accept;
  logic              req_ok;
  logic              req_mis;
  logic              mis_q;
  logic [ADDR_W-1:0] addr_al;
  logic [ADDR_W-1:0] addr_nx;
  logic [31:0]       win_lo;
  logic [31:0]       win_hi;
  logic [31:0]       ld_data;
  logic [31:0]       st_lo;
  logic [31:0]       st_hi;

  assign accept  = req_valid_i && (state_q == IDLE);
  assign req_ok  = funct3_ok(req_store_i, req_funct3_i);
  assign req_mis = is_misaligned(req_funct3_i, req_addr_i[1:0]);
  assign mis_q   = is_misaligned(funct3_q, addr_q[1:0]);
  assign addr_al = {addr_q[ADDR_W-1:2], 2'b00};
  assign addr_nx = addr_al + ADDR_W'(4);
  assign err_d   = !req_ok || (req_mis && !MISALIGN_SPLIT);

  // Loads see the live read word; stores merge into the words captured earlier.
  assign win_lo = (state_q == RD0) ? mem_dout_i : rd0_q;
`ifdef RISC_V_LSU_MISALIGN_SPLIT_EN
  assign win_hi = ((state_q == RD0) || (state_q == RD1)) ? mem_dout_i : rd1_q;
`else
  assign win_hi = win_lo;
`endif

  risc_v_lsu_align u_align (
    .funct3_i  (funct3_q),
    .offset_i  (addr_q[1:0]),
    .word_lo_i (win_lo),
    .word_hi_i (win_hi),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data),
    .st_lo_o   (st_lo),
    .st_hi_o   (st_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        err_q <= err_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      store_q  <= req_store_i;
      funct3_q <= req_funct3_i;
      addr_q   <= req_addr_i;
      wdata_q  <= req_wdata_i;
      rdata_q  <= '0;
    end
    if (state_q == RD0) begin
      rd0_q <= mem_dout_i;
    end
    if (!store_q && (state_q == RD0) && !mis_q) begin
      rdata_q <= ld_data;
    end
`ifdef RISC_V_LSU_MISALIGN_SPLIT_EN
    if (state_q == RD1) begin
      rd1_q <= mem_dout_i;
      if (!store_q) begin
        rdata_q <= ld_data;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (err_d) begin
            state_d = RESP;
          end else if (req_store_i && (req_funct3_i == F3_W) && !req_mis) begin
            state_d = WR0;
          end else begin
            state_d = RD0;
          end
        end
      end
      RD0: begin
`ifdef RISC_V_LSU_MISALIGN_SPLIT_EN
        if (mis_q) begin
          state_d = RD1;
        end else
`endif
        if (store_q) begin
          state_d = WR0;
        end else begin
          state_d = RESP;
        end
      end
`ifdef RISC_V_LSU_MISALIGN_SPLIT_EN
      RD1: state_d = store_q ? WR0 : RESP;
      WR0: state_d = mis_q ? WR1 : RESP;
      WR1: state_d = RESP;
`else
      WR0: state_d = RESP;
`endif
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = (state_q == IDLE);
    resp_valid_o = (state_q == RESP);
    resp_err_o   = (state_q == RESP) && err_q;
    resp_rdata_o = (state_q == RESP) ? rdata_q : 32'd0;
    mem_addr_o   = '0;
    mem_din_o    = 32'd0;
    mem_we_o     = 1'b0;
    case (state_q)
      RD0: mem_addr_o = addr_al;
      WR0: begin
        mem_addr_o = addr_al;
        mem_din_o  = st_lo;
        mem_we_o   = 1'b1;
      end
`ifdef RISC_V_LSU_MISALIGN_SPLIT_EN
      RD1: mem_addr_o = addr_nx;
      WR1: begin
        mem_addr_o = addr_nx;
        mem_din_o  = st_hi;
        mem_we_o   = 1'b1;
      end
`endif
      default: begin
        mem_addr_o = '0;
      end
    endcase
  end

`ifndef RISC_V_LSU_MISALIGN_SPLIT_EN
  // The high-word path only exists in the split build.
  logic unused_hi;
  assign unused_hi = ^{addr_nx, st_hi};
`endif

endmodule

// File: tb/tb_risc_v_load_store_unit.sv
// Directed self-checking bench for risc_v_load_store_unit with a behavioural word memory.
module tb_risc_v_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_we;

  logic [31:0] mem [0:63];
  int          we_cnt = 0;
  int          acc_cnt = 0;
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_val = 32'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  risc_v_load_store_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_store_i  (req_store),
    .req_funct3_i (req_funct3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err),
    .mem_addr_o   (mem_addr),
    .mem_din_o    (mem_din),
    .mem_we_o     (mem_we),
    .mem_dout_i   (mem_dout)
  );

  assign mem_dout = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_din;
    else if (pl_en) mem[pl_idx] <= pl_val;
    if (mem_we) we_cnt <= we_cnt + 1;
    if (mem_addr != 32'd0) acc_cnt <= acc_cnt + 1;
  end

  task automatic set_mem(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_idx = idx; pl_val = val; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request, wait (bounded) for the response, then complete the handshake.
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd,
                        output logic er, output int wes, output int accs);
    int w0, a0;
    @(negedge clk);
    w0 = we_cnt; a0 = acc_cnt;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata; er = resp_err;
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    wes = we_cnt - w0; accs = acc_cnt - a0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    #12;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_din !== 32'd0) begin errors++; $display("FAIL reset_mem_din got %h want 0", mem_din); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_load();
    logic [2:0]  f3s [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b101};
    logic [31:0] ads [7] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10, 32'h13, 32'h10};
    logic [31:0] exp [7] = '{32'hFFFFFFBE, 32'h000000BE, 32'hFFFFDEAD, 32'h0000DEAD,
                             32'hDEADBEEF, 32'hFFFFFFDE, 32'h0000BEEF};
    int lat, wes, accs; logic [31:0] rd; logic er;
    set_mem(6'd4, 32'hDEADBEEF);
    for (int i = 0; i < 7; i++) begin
      do_req(1'b0, f3s[i], ads[i], 32'd0, lat, rd, er, wes, accs);
      checks++; if (rd !== exp[i]) begin errors++; $display("FAIL load%0d_rdata got %h want %h", i, rd, exp[i]); end
      checks++; if (lat != 2) begin errors++; $display("FAIL load%0d_latency got %0d want 2", i, lat); end
      checks++; if (er !== 1'b0 || wes != 0) begin errors++; $display("FAIL load%0d_err_we got err=%b we=%0d want 0/0", i, er, wes); end
    end
  endtask

  task automatic test_store();
    int lat, wes, accs; logic [31:0] rd; logic er;
    set_mem(6'd4, 32'hDEADBEEF);
    set_mem(6'd5, 32'h00C0FFEE);
    do_req(1'b1, 3'b001, 32'h12, 32'h00001234, lat, rd, er, wes, accs);
    checks++; if (mem[4] !== 32'h1234BEEF) begin errors++; $display("FAIL sh_mem got %h want 1234beef", mem[4]); end
    checks++; if (wes != 1) begin errors++; $display("FAIL sh_we_pulses got %0d want 1", wes); end
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL sh_resp got err=%b rdata=%h want 0/0", er, rd); end
    checks++; if (lat != 3) begin errors++; $display("FAIL sh_latency got %0d want 3", lat); end
    do_req(1'b1, 3'b000, 32'h11, 32'hFFFFFFAB, lat, rd, er, wes, accs);
    checks++; if (mem[4] !== 32'h1234ABEF || wes != 1) begin errors++; $display("FAIL sb_mem got %h we=%0d want 1234abef we=1", mem[4], wes); end
    do_req(1'b1, 3'b010, 32'h10, 32'hCAFEF00D, lat, rd, er, wes, accs);
    checks++; if (mem[4] !== 32'hCAFEF00D || wes != 1) begin errors++; $display("FAIL sw_mem got %h we=%0d want cafef00d we=1", mem[4], wes); end
    checks++; if (lat != 2 || er !== 1'b0) begin errors++; $display("FAIL sw_resp got lat=%0d err=%b want 2/0", lat, er); end
    checks++; if (mem[5] !== 32'h00C0FFEE) begin errors++; $display("FAIL sw_neighbour got %h want 00c0ffee", mem[5]); end
  endtask

  task automatic test_misalign();
    int lat, wes, accs; logic [31:0] rd; logic er;
    set_mem(6'd4, 32'hDEADBEEF);
    set_mem(6'd5, 32'h00C0FFEE);
    do_req(1'b0, 3'b010, 32'h12, 32'd0, lat, rd, er, wes, accs);
`ifdef RISC_V_LSU_MISALIGN_SPLIT_EN
    checks++; if (rd !== 32'hFFEEDEAD || er !== 1'b0) begin errors++; $display("FAIL lw_mis got %h err=%b want ffeedead/0", rd, er); end
    checks++; if (lat != 3) begin errors++; $display("FAIL lw_mis_latency got %0d want 3", lat); end
`else
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL lw_mis got %h err=%b want 0/1", rd, er); end
    checks++; if (lat != 1 || accs != 0) begin errors++; $display("FAIL lw_mis_noaccess got lat=%0d acc=%0d want 1/0", lat, accs); end
`endif
    do_req(1'b0, 3'b001, 32'h11, 32'd0, lat, rd, er, wes, accs);
`ifdef RISC_V_LSU_MISALIGN_SPLIT_EN
    checks++; if (rd !== 32'hFFFFADBE || er !== 1'b0) begin errors++; $display("FAIL lh_mis got %h err=%b want ffffadbe/0", rd, er); end
`else
    checks++; if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL lh_mis got %h err=%b want 0/1", rd, er); end
`endif
    do_req(1'b1, 3'b001, 32'h13, 32'h00005678, lat, rd, er, wes, accs);
`ifdef RISC_V_LSU_MISALIGN_SPLIT_EN
    checks++; if (mem[4] !== 32'h78ADBEEF || mem[5] !== 32'h00C0FF56) begin errors++; $display("FAIL sh_mis_mem got %h %h want 78adbeef 00c0ff56", mem[4], mem[5]); end
    checks++; if (wes != 2 || lat != 5 || er !== 1'b0) begin errors++; $display("FAIL sh_mis_seq got we=%0d lat=%0d err=%b want 2/5/0", wes, lat, er); end
    do_req(1'b1, 3'b001, 32'h11, 32'h00009ABC, lat, rd, er, wes, accs);
    checks++; if (mem[4] !== 32'h789ABCEF || mem[5] !== 32'h00C0FF56 || wes != 2) begin errors++; $display("FAIL sh_mis_hi_rewrite got %h %h we=%0d want 789abcef 00c0ff56 2", mem[4], mem[5], wes); end
`else
    checks++; if (mem[4] !== 32'hDEADBEEF || mem[5] !== 32'h00C0FFEE) begin errors++; $display("FAIL sh_mis_mem got %h %h want unchanged", mem[4], mem[5]); end
    checks++; if (wes != 0 || accs != 0 || er !== 1'b1) begin errors++; $display("FAIL sh_mis_seq got we=%0d acc=%0d err=%b want 0/0/1", wes, accs, er); end
`endif
  endtask

  task automatic test_bad_funct3();
    int lat, wes, accs; logic [31:0] rd; logic er;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b011; req_addr = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin errors++; $display("FAIL bad_f3_resp got v=%b err=%b rdata=%h want 1/1/0", resp_valid, resp_err, resp_rdata); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'd0 || req_ready !== 1'b0 || mem_addr !== 32'd0)
        begin errors++; $display("FAIL bad_f3_hold%0d got v=%b err=%b rdata=%h rdy=%b addr=%h want 1/1/0/0/0", i, resp_valid, resp_err, resp_rdata, req_ready, mem_addr); end
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bad_f3_release got v=%b rdy=%b want 0/1", resp_valid, req_ready); end
    do_req(1'b1, 3'b011, 32'h10, 32'h12345678, lat, rd, er, wes, accs);
    checks++; if (er !== 1'b1 || wes != 0 || accs != 0 || lat != 1) begin errors++; $display("FAIL bad_store got err=%b we=%0d acc=%0d lat=%0d want 1/0/0/1", er, wes, accs, lat); end
  endtask

  task automatic test_back_to_back();
    int lat, wes, accs; logic [31:0] rd; logic er;
    set_mem(6'd4, 32'h8899AABB);
    do_req(1'b0, 3'b010, 32'h10, 32'd0, lat, rd, er, wes, accs);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", req_ready); end
    checks++; if (rd !== 32'h8899AABB) begin errors++; $display("FAIL b2b_first got %h want 8899aabb", rd); end
    do_req(1'b0, 3'b100, 32'h12, 32'd0, lat, rd, er, wes, accs);
    checks++; if (rd !== 32'h00000099 || lat != 2) begin errors++; $display("FAIL b2b_second got %h lat=%0d want 00000099/2", rd, lat); end
  endtask

  task automatic test_reset_mid();
    int w0;
    set_mem(6'd4, 32'h11223344);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h000000AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    w0 = we_cnt;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rstmid_in_wr0 got we=%b want 1", mem_we); end
    #1 rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0 || mem_addr !== 32'd0) begin errors++; $display("FAIL rstmid_we_drop got we=%b addr=%h want 0/0", mem_we, mem_addr); end
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle%0d got v=%b rdy=%b want 0/1", i, resp_valid, req_ready); end
    end
    checks++; if (mem[4] !== 32'h11223344 || we_cnt != w0) begin errors++; $display("FAIL rstmid_mem got %h writes=%0d want 11223344/0", mem[4], we_cnt - w0); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_misalign();
    test_bad_funct3();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
